// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit register bank. Each cycle it does one of four
// operations: a per-bit JK flip-flop update, count up, count down, or shift
// left. It also has a sticky overflow/underflow flag.
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   rst      - synchronous active-high reset (q <= RST_VAL, ovf <= 0)
//   en       - cycle enable; when low, q and ovf hold (ovf_clr still works)
//   mode     - 00 JK, 01 count up, 10 count down, 11 shift left
//   j, k     - per-bit JK inputs (JK mode only)
//   sin      - serial input, shifted into bit 0 in shift mode
//   ovf_clr  - synchronous clear of the sticky ovf flag
//   q, qb    - registered state and its bitwise complement
//   sout     - serial output, q[WIDTH-1]
//   tc       - combinational terminal count (all ones counting up, zero down)
//   ovf      - registered sticky flag: set on an enabled edge with tc=1
//
// Build option: define JK_REG_BANK_SAT_EN to make the counter saturate at
// its terminal count instead of wrapping. ovf sets in both builds.

module jk_reg_bank #(
   parameter int unsigned       WIDTH   = 8,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic             sin,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             sout,
   output logic             tc,
   output logic             ovf
);

   localparam logic [1:0] MODE_JK    = 2'b00;
   localparam logic [1:0] MODE_UP    = 2'b01;
   localparam logic [1:0] MODE_DOWN  = 2'b10;
   localparam logic [1:0] MODE_SHIFT = 2'b11;

   logic [WIDTH-1:0] q_q, q_d;
   logic             ovf_q, ovf_d;
   logic             tc_c;

   // Terminal count: the next count step would wrap (or saturate).
   always_comb begin
      tc_c = 1'b0;
      if ((mode == MODE_UP) && (q_q == {WIDTH{1'b1}})) begin
         tc_c = 1'b1;
      end else if ((mode == MODE_DOWN) && (q_q == '0)) begin
         tc_c = 1'b0 | 1'b1;
      end
   end

   // Next state of the register.
   always_comb begin
      q_d = q_q;
      if (en) begin
         unique case (mode)
            // Per bit: JK=00 hold, 01 clear, 10 set, 11 toggle.
            MODE_JK:    q_d = (j & ~q_q) | (~k & q_q);
`ifdef JK_REG_BANK_SAT_EN
            MODE_UP:    q_d = tc_c ? q_q : q_q + WIDTH'(1);
            MODE_DOWN:  q_d = tc_c ? q_q : q_q - WIDTH'(1);
`else
            MODE_UP:    q_d = q_q + WIDTH'(1);
            MODE_DOWN:  q_d = q_q - WIDTH'(1);
`endif
            MODE_SHIFT: q_d = {q_q[WIDTH-2:0], sin};
            default:    q_d = q_q;
         endcase
      end
   end

   // Sticky flag. It is cleared first and set afterwards, so a set on the
   // same edge as a clear leaves ovf at 1.
   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (en && tc_c) begin
         ovf_d = 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q   <= RST_VAL;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ovf_q <= ovf_d;
      end
   end

   assign q    = q_q;
   assign qb   = ~q_q;
   assign sout = q_q[WIDTH-1];
   assign tc   = tc_c;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Testbench for jk_reg_bank (WIDTH=4, RST_VAL=0). It runs the directed
// scenarios first and then a randomized run. Every output is compared with an
// integer reference model that works from the operation rules.

module tb_jk_reg_bank;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst, en, sin, ovf_clr;
   logic [1:0]   mode;
   logic [W-1:0] j, k;
   logic [W-1:0] q, qb;
   logic         sout, tc, ovf;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   int m_q   = 0;
   int m_ovf = 0;

`ifdef JK_REG_BANK_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   jk_reg_bank #(.WIDTH(W), .RST_VAL(4'b0000)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .sin(sin),
      .ovf_clr(ovf_clr), .q(q), .qb(qb), .sout(sout), .tc(tc), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_tc(input int qv, input int md);
      return ((md == 1 && qv == 15) || (md == 2 && qv == 0)) ? 1 : 0;
   endfunction

   // Model update for one clock edge, using the inputs that were applied.
   task automatic model_edge();
      int t;
      int nq;
      t = model_tc(m_q, int'(mode));
      if (rst) begin
         m_q   = 0;
         m_ovf = 0;
      end else begin
         if (ovf_clr) m_ovf = 0;
         if (en && t == 1) m_ovf = 1;
         if (en) begin
            case (int'(mode))
               0: begin
                  nq = 0;
                  for (int i = 0; i < 4; i++) begin
                     int b;
                     b = (m_q >> i) & 1;
                     if (j[i] && k[i])  b = 1 - b;
                     else if (j[i])     b = 1;
                     else if (k[i])     b = 0;
                     nq = nq + (b << i);
                  end
                  m_q = nq;
               end
               1: if (!(SAT && m_q == 15)) m_q = (m_q + 1) % 16;
               2: if (!(SAT && m_q == 0))  m_q = (m_q + 15) % 16;
               default: m_q = (m_q * 2 + int'(sin)) % 16;
            endcase
         end
      end
   endtask

   task automatic check_outputs();
      check("q",    32'(q),    32'(m_q));
      check("qb",   32'(qb),   32'((~m_q) & 15));
      check("sout", 32'(sout), 32'((m_q >> 3) & 1));
      check("ovf",  32'(ovf),  32'(m_ovf));
      check("tc",   32'(tc),   32'(model_tc(m_q, int'(mode))));
   endtask

   task automatic drive(input logic r, input logic e, input logic [1:0] md,
                        input logic [3:0] jv, input logic [3:0] kv,
                        input logic s, input logic c);
      rst = r; en = e; mode = md; j = jv; k = kv; sin = s; ovf_clr = c;
   endtask

   // One clock edge: update the model, then compare just after the edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   initial begin
      drive(1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
      step();
      check("rst_q", 32'(q), 32'h0);
      check("rst_qb", 32'(qb), 32'hF);

      // JK set/clear, toggle, then hold.
      drive(1'b0, 1'b1, 2'b00, 4'b1010, 4'b0101, 1'b0, 1'b0); step();
      check("jk_load", 32'(q), 32'hA);
      check("jk_load_qb", 32'(qb), 32'h5);
      drive(1'b0, 1'b1, 2'b00, 4'b1111, 4'b1111, 1'b0, 1'b0); step();
      check("jk_toggle", 32'(q), 32'h5);
      drive(1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0); step();
      check("jk_hold", 32'(q), 32'h5);

      // Count up through all ones.
      drive(1'b0, 1'b1, 2'b00, 4'b1110, 4'b0001, 1'b0, 1'b0); step();
      drive(1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0, 1'b0);
      #1 check("up_tc0", 32'(tc), 32'h0);
      step();
      check("up_ones", 32'(q), 32'hF);
      check("up_tc", 32'(tc), 32'h1);
      step();
      check("up_wrap", 32'(q), SAT ? 32'hF : 32'h0);
      check("up_ovf", 32'(ovf), 32'h1);

      // Count down through zero, with ovf_clr on the same edge.
      drive(1'b0, 1'b1, 2'b00, 4'b0001, 4'b1110, 1'b0, 1'b1); step();
      check("clr_ovf", 32'(ovf), 32'h0);
      drive(1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0, 1'b0); step();
      check("dn_zero", 32'(q), 32'h0);
      drive(1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0, 1'b1); step();
      check("dn_wrap", 32'(q), SAT ? 32'h0 : 32'hF);
      check("set_wins", 32'(ovf), 32'h1);

      // Shift in 1,0,1,1 starting from zero.
      drive(1'b0, 1'b1, 2'b00, 4'b0000, 4'b1111, 1'b0, 1'b0); step();
      drive(1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 1'b1, 1'b0); step();
      check("sh1", 32'(q), 32'h1);
      sin = 1'b0; step(); check("sh2", 32'(q), 32'h2);
      sin = 1'b1; step(); check("sh3", 32'(q), 32'h5);
      sin = 1'b1; step(); check("sh4", 32'(q), 32'hB);
      check("sh_sout", 32'(sout), 32'h1);

      // With en low, q and ovf hold; ovf_clr still clears ovf.
      drive(1'b0, 1'b1, 2'b00, 4'b1111, 4'b0000, 1'b0, 1'b0); step();
      drive(1'b0, 1'b0, 2'b01, 4'h0, 4'h0, 1'b0, 1'b0); step();
      check("en0_hold", 32'(q), 32'hF);
      check("en0_tc", 32'(tc), 32'h1);
      check("en0_ovf", 32'(ovf), 32'h1);
      ovf_clr = 1'b1; step();
      check("en0_clr", 32'(ovf), 32'h0);

      // Reset in the middle of a count.
      drive(1'b0, 1'b1, 2'b00, 4'b0101, 4'b1010, 1'b0, 1'b0); step();
      drive(1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0, 1'b0); step();
      check("mid_q", 32'(q), 32'h6);
      rst = 1'b1; step();
      check("mid_rst_q", 32'(q), 32'h0);
      check("mid_rst_ovf", 32'(ovf), 32'h0);
      rst = 1'b0; step();
      check("resume", 32'(q), 32'h1);

      // Randomized run against the model.
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
               2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
               1'($urandom), ($urandom_range(0, 7) == 0));
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
